// File: rtl/onehot_priority_sel.sv
// Strict-priority one-hot grant with optional sticky hold, plus two AND-OR
// one-hot multiplexers routing din lanes by the grant and by an external select.
module onehot_priority_sel #(
    parameter int N_PORTS = 2,
    parameter int W_DATA  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        canchange,
    input  logic [N_PORTS-1:0]          req,
    output logic [N_PORTS-1:0]          gnt,
    output logic [W_DATA-1:0]           gnt_data,
    input  logic [N_PORTS*W_DATA-1:0]   din,
    input  logic [N_PORTS-1:0]          mux_sel,
    output logic [W_DATA-1:0]           mux_out
);

    logic [N_PORTS-1:0] last_gnt;
    logic [N_PORTS-1:0] lowest_req;
    logic               hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= '0;
        end else begin
            last_gnt <= gnt;
        end
    end

    // Two's-complement isolate of the lowest set bit; zero when req is zero.
    assign lowest_req = req & (~req + {{(N_PORTS-1){1'b0}}, 1'b1});
    assign hold       = canchange && (|(last_gnt & req));

    always_comb begin
        gnt = lowest_req;
        if (hold) begin
            gnt = last_gnt;
        end
    end

    // Multi-hot selects OR the chosen lanes together by construction.
    always_comb begin
        gnt_data = '0;
        mux_out  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            gnt_data = gnt_data | (din[i*W_DATA +: W_DATA] & {W_DATA{gnt[i]}});
            mux_out  = mux_out  | (din[i*W_DATA +: W_DATA] & {W_DATA{mux_sel[i]}});
        end
    end

endmodule

// File: tb/tb_onehot_priority_sel.sv
// Directed and randomized checks of onehot_priority_sel against a behavioural
// priority/hold model kept in the bench.
module tb_onehot_priority_sel;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           canchange;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [W-1:0]   gnt_data;
    logic [N*W-1:0] din;
    logic [N-1:0]   mux_sel;
    logic [W-1:0]   mux_out;

    int checks;
    int errors;
    logic [N-1:0] m_last;

    onehot_priority_sel #(.N_PORTS(N), .W_DATA(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .canchange(canchange),
        .req(req),
        .gnt(gnt),
        .gnt_data(gnt_data),
        .din(din),
        .mux_sel(mux_sel),
        .mux_out(mux_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] ref_gnt(input logic cc, input logic [N-1:0] r,
                                             input logic [N-1:0] last);
        if (cc && ((last & r) != '0)) return last;
        for (int i = 0; i < N; i++) begin
            if (r[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    function automatic logic [W-1:0] ref_mux(input logic [N*W-1:0] d, input logic [N-1:0] s);
        logic [W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            if (s[i]) acc = acc | d[i*W +: W];
        end
        return acc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic cc, input logic [N-1:0] r, input logic [N-1:0] ms,
                         input string tag);
        logic [N-1:0] eg;
        canchange = cc;
        req       = r;
        mux_sel   = ms;
        #1;
        eg = ref_gnt(cc, r, m_last);
        check({tag, "_gnt"},      32'(gnt),      32'(eg));
        check({tag, "_gnt_data"}, 32'(gnt_data), 32'(ref_mux(din, eg)));
        check({tag, "_mux_out"},  32'(mux_out),  32'(ref_mux(din, ms)));
        check({tag, "_onehot0"},  32'($onehot0(gnt)), 32'd1);
        check({tag, "_subset"},   32'(gnt & ~req), 32'd0);
    endtask

    task automatic tick();
        logic [N-1:0] eg;
        eg = ref_gnt(canchange, req, m_last);
        @(posedge clk);
        if (rst_n) m_last = eg;
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        m_last    = '0;
        rst_n     = 1'b0;
        canchange = 1'b0;
        req       = '0;
        mux_sel   = '0;
        din       = {8'h44, 8'h33, 8'h22, 8'h11};
        #2;

        // Reset held: strict priority only, edges do not register.
        drive(1'b1, 4'b1010, 4'b0000, "rst_hold");
        check("rst_gnt_const", 32'(gnt), 32'h2);
        check("rst_data_const", 32'(gnt_data), 32'h22);
        tick();
        drive(1'b1, 4'b1010, 4'b0000, "rst_hold2");
        rst_n = 1'b1;
        tick();
        // last_gnt now 0010, so 1011 with hold keeps port 1.
        drive(1'b1, 4'b1011, 4'b0000, "follow");
        check("follow_const", 32'(gnt), 32'h2);
        tick();

        drive(1'b0, 4'b1100, 4'b0000, "prio");
        check("prio_const", 32'(gnt), 32'h4);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, "idle");
        check("idle_data_const", 32'(gnt_data), 32'h0);
        tick();

        drive(1'b1, 4'b1000, 4'b0000, "hold_c1");
        tick();
        drive(1'b1, 4'b1001, 4'b0000, "hold_c2");
        check("hold_c2_const", 32'(gnt), 32'h8);
        tick();
        drive(1'b0, 4'b1001, 4'b0000, "hold_c3");
        check("hold_c3_const", 32'(gnt), 32'h1);
        tick();

        drive(1'b1, 4'b1000, 4'b0000, "drop_setup");
        tick();
        drive(1'b1, 4'b0110, 4'b0000, "drop");
        check("drop_const", 32'(gnt), 32'h2);
        tick();

        drive(1'b0, 4'b0000, 4'b0000, "mux0");
        check("mux0_const", 32'(mux_out), 32'h00);
        drive(1'b0, 4'b0000, 4'b0100, "mux2");
        check("mux2_const", 32'(mux_out), 32'h33);
        drive(1'b0, 4'b0000, 4'b0011, "mux01");
        check("mux01_const", 32'(mux_out), 32'h33);
        tick();

        // Async reset between edges must drop the held grant immediately.
        drive(1'b1, 4'b1000, 4'b0000, "async_setup");
        tick();
        drive(1'b1, 4'b1001, 4'b0000, "async_pre");
        check("async_pre_const", 32'(gnt), 32'h8);
        #2;
        rst_n  = 1'b0;
        m_last = '0;
        #1;
        check("async_gnt", 32'(gnt), 32'(ref_gnt(1'b1, 4'b1001, m_last)));
        check("async_const", 32'(gnt), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 400; k++) begin
            din = {$urandom, $urandom} >> 0;
            din = N*W'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #1;
                rst_n  = 1'b0;
                m_last = '0;
            end else begin
                rst_n = 1'b1;
            end
            drive(1'(($urandom_range(0, 3) != 0)), N'($urandom), N'($urandom), "rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
